// File: rtl/life_gen_engine.sv
// Game-of-Life generation engine: ping-pong cell banks, one toroidal generation per start,
// result streamed into text VRAM as glyph word pairs over an Avalon-MM write master.
module life_gen_engine #(
   parameter int unsigned COLS        = 64,
   parameter int unsigned ROWS        = 48,
   parameter logic [13:0] VRAM_BASE   = 14'h0000,
   parameter logic [15:0] ALIVE_GLYPH = 16'h2A10,
   parameter logic [15:0] DEAD_GLYPH  = 16'h2000,
   parameter bit          SYNC_VSYNC  = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    start,
   input  logic                    step,
   input  logic                    vs,
   input  logic                    seed_we,
   input  logic [$clog2(ROWS)-1:0] seed_row,
   input  logic [$clog2(COLS)-1:0] seed_col,
   input  logic                    seed_val,
   output logic [13:0]             m_address,
   output logic                    m_write,
   output logic [31:0]             m_writedata,
   output logic [3:0]              m_byteenable,
   input  logic                    m_waitrequest,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             gen_count
);

   localparam int unsigned RW   = $clog2(ROWS);
   localparam int unsigned CW   = $clog2(COLS);
   localparam int unsigned HALF = COLS / 2;
   localparam int unsigned KW   = $clog2(HALF);

   typedef enum logic [2:0] {IDLE, WAIT_VS, COMPUTE, WRITE, DONE} state_t;

   state_t            state, state_d;
   logic [RW-1:0]     row, row_d;
   logic [KW-1:0]     k, k_d;
   logic              step_q, step_d;
   logic              cur_bank, bank_d;
   logic [COLS-1:0]   row_buf, buf_d;
   logic [13:0]       addr_d;
   logic              mwr_d;
   logic [31:0]       data_d;
   logic              busy_d, done_d;
   logic [15:0]       gen_d;
   logic [2:0]        vs_s;
   logic              vs_rise;
   logic              seed_wr, res_wr;
   logic [RW-1:0]     prev_idx, next_idx;
   logic [COLS-1:0]   row_p, row_c, row_n, next_row;
   logic [CW-1:0]     nxt_lsb;

   logic [COLS-1:0]   grid [2][ROWS];

   assign m_byteenable = 4'b1111;
   assign vs_rise      = vs_s[1] & ~vs_s[2];

   function automatic logic [31:0] word_of(input logic [1:0] cells);
      return {cells[1] ? ALIVE_GLYPH : DEAD_GLYPH, cells[0] ? ALIVE_GLYPH : DEAD_GLYPH};
   endfunction

   // Toroidal neighbourhood of the row being computed
   assign prev_idx = (row == '0) ? RW'(ROWS - 1) : row - RW'(1);
   assign next_idx = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
   assign row_p    = grid[cur_bank][prev_idx];
   assign row_c    = grid[cur_bank][row];
   assign row_n    = grid[cur_bank][next_idx];

   for (genvar c = 0; c < COLS; c++) begin : g_cell
      localparam int unsigned CL = (c + COLS - 1) % COLS;
      localparam int unsigned CR = (c + 1) % COLS;
      logic [3:0] n;
      assign n = 4'(row_p[CL]) + 4'(row_p[c]) + 4'(row_p[CR]) + 4'(row_c[CL]) +
                 4'(row_c[CR]) + 4'(row_n[CL]) + 4'(row_n[c]) + 4'(row_n[CR]);
      assign next_row[c] = step_q ? ((n == 4'd3) | (row_c[c] & (n == 4'd2))) : row_c[c];
   end

   assign nxt_lsb = {k + KW'(1), 1'b0};

   // Next-state and registered-output logic
   always_comb begin
      state_d = state;
      row_d   = row;
      k_d     = k;
      step_d  = step_q;
      bank_d  = cur_bank;
      buf_d   = row_buf;
      mwr_d   = m_write;
      addr_d  = m_address;
      data_d  = m_writedata;
      done_d  = 1'b0;
      gen_d   = gen_count;
      seed_wr = 1'b0;
      res_wr  = 1'b0;
      case (state)
         IDLE: begin
            seed_wr = seed_we;
            if (start) begin
               step_d  = step;
               row_d   = '0;
               state_d = SYNC_VSYNC ? WAIT_VS : COMPUTE;
            end
         end
         WAIT_VS: if (vs_rise) state_d = COMPUTE;
         COMPUTE: begin
            res_wr  = 1'b1;
            buf_d   = next_row;
            k_d     = '0;
            mwr_d   = 1'b1;
            addr_d  = VRAM_BASE + 14'(row) * 14'(HALF);
            data_d  = word_of(next_row[1:0]);
            state_d = WRITE;
         end
         WRITE: begin
            if (m_write && !m_waitrequest) begin
               if (k == KW'(HALF - 1)) begin
                  mwr_d = 1'b0;
                  if (row == RW'(ROWS - 1)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     row_d   = row + RW'(1);
                     state_d = COMPUTE;
                  end
               end else begin
                  k_d    = k + KW'(1);
                  addr_d = m_address + 14'd1;
                  data_d = word_of(row_buf[nxt_lsb +: 2]);
               end
            end
         end
         DONE: begin
            bank_d  = ~cur_bank;
            if (step_q) gen_d = gen_count + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= IDLE;
         row         <= '0;
         k           <= '0;
         step_q      <= 1'b0;
         cur_bank    <= 1'b0;
         row_buf     <= '0;
         m_write     <= 1'b0;
         m_address   <= '0;
         m_writedata <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         gen_count   <= '0;
         vs_s        <= '0;
      end else begin
         state       <= state_d;
         row         <= row_d;
         k           <= k_d;
         step_q      <= step_d;
         cur_bank    <= bank_d;
         row_buf     <= buf_d;
         m_write     <= mwr_d;
         m_address   <= addr_d;
         m_writedata <= data_d;
         busy        <= busy_d;
         done        <= done_d;
         gen_count   <= gen_d;
         vs_s        <= {vs_s[1:0], vs};
      end
   end

   // Cell banks are deliberately not reset; the source bank is never written mid-pass
   always_ff @(posedge CLK) begin
      if (seed_wr) grid[cur_bank][seed_row][seed_col] <= seed_val;
      if (res_wr)  grid[~cur_bank][row] <= next_row;
   end

endmodule

// File: tb/tb_life_gen_engine.sv
// Scoreboard bench for life_gen_engine: expected VRAM words are queued per pass and a
// monitor pops and compares each accepted write; directed checks cover hand-derived cells.
module tb_life_gen_engine;

   localparam int ROWS = 48;
   localparam int COLS = 64;
   localparam int HALF = 32;
   localparam int NW   = ROWS * HALF;
   localparam logic [15:0] AG = 16'h2A10;
   localparam logic [15:0] DG = 16'h2000;

   logic        CLK = 1'b0;
   logic        RESET, start, step, vs, seed_we, seed_val, m_waitrequest, v_start;
   logic [5:0]  seed_row, seed_col;
   logic [13:0] m_address, v_address;
   logic        m_write, v_write, busy, v_busy, done, v_done;
   logic [31:0] m_writedata, v_writedata;
   logic [3:0]  m_byteenable, v_byteenable;
   logic [15:0] gen_count, v_gen;

   always #5 CLK = ~CLK;

   life_gen_engine #(.SYNC_VSYNC(1'b0)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .step(step), .vs(vs),
      .seed_we(seed_we), .seed_row(seed_row), .seed_col(seed_col), .seed_val(seed_val),
      .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
      .busy(busy), .done(done), .gen_count(gen_count));

   life_gen_engine #(.SYNC_VSYNC(1'b1)) dut_vs (
      .CLK(CLK), .RESET(RESET), .start(v_start), .step(step), .vs(vs),
      .seed_we(1'b0), .seed_row(6'd0), .seed_col(6'd0), .seed_val(1'b0),
      .m_address(v_address), .m_write(v_write), .m_writedata(v_writedata),
      .m_byteenable(v_byteenable), .m_waitrequest(1'b0),
      .busy(v_busy), .done(v_done), .gen_count(v_gen));

   int checks = 0;
   int passes = 0;
   int wr_count = 0;
   logic [45:0] exp_q [$];
   logic [31:0] vram [NW];
   bit          mdl [ROWS][COLS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [15:0] g(input bit c);
      return c ? AG : DG;
   endfunction

   function automatic void clear_model();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mdl[r][c] = 1'b0;
   endfunction

   function automatic void life_step();
      bit nx [ROWS][COLS];
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            int n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0)
                     n += int'(mdl[(r + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
            nx[r][c] = (n == 3) || (mdl[r][c] && n == 2);
         end
      mdl = nx;
   endfunction

   function automatic void push_expected();
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < HALF; k++)
            exp_q.push_back({14'(r * HALF + k), g(mdl[r][2*k+1]), g(mdl[r][2*k])});
   endfunction

   // Monitor: every accepted write pops one expected word
   initial forever begin
      @(negedge CLK);
      #1;
      if (m_write && !m_waitrequest) begin
         wr_count++;
         if (int'(m_address) < NW) vram[m_address] = m_writedata;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_write: got addr %h data %h, expected no write", m_address, m_writedata);
         end else begin
            logic [45:0] e;
            e = exp_q.pop_front();
            check("word", 64'({m_address, m_writedata}), 64'(e));
         end
      end
   end

   task automatic load_grid();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            @(negedge CLK);
            seed_we = 1'b1; seed_row = 6'(r); seed_col = 6'(c); seed_val = mdl[r][c];
         end
      @(negedge CLK);
      seed_we = 1'b0;
   endtask

   task automatic run_pass(input logic s, input int exp_cyc, input bit do_stall, input bit do_guard);
      int cyc = 0;
      int stall_left = 0;
      bit stalled = 1'b0;
      logic [13:0] ca = '0;
      logic [31:0] cd = '0;
      wr_count = 0;
      @(negedge CLK);
      start = 1'b1; step = s;
      @(posedge CLK);
      while (cyc < 5000) begin
         @(negedge CLK);
         cyc++;
         start = 1'b0; seed_we = 1'b0;
         if (do_guard && cyc == 70) begin
            start = 1'b1; step = 1'b1;
            seed_we = 1'b1; seed_row = 6'd5; seed_col = 6'd5; seed_val = 1'b1;
         end
         if (stall_left > 0) begin
            check("stall_addr", 64'(m_address), 64'(ca));
            check("stall_data", 64'(m_writedata), 64'(cd));
            stall_left--;
            if (stall_left == 0) m_waitrequest = 1'b0;
         end else if (do_stall && !stalled && m_write && m_address == 14'd3) begin
            m_waitrequest = 1'b1; stall_left = 5; stalled = 1'b1;
            ca = m_address; cd = m_writedata;
         end
         if (done) break;
      end
      check("done_latency", 64'(cyc), 64'(exp_cyc));
      @(negedge CLK);
      check("done_pulse_end", 64'({done, busy}), 64'(0));
      check("write_count", 64'(wr_count), 64'(NW));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int n;
      RESET = 1'b0; start = 1'b0; step = 1'b0; vs = 1'b1; seed_we = 1'b0;
      seed_row = '0; seed_col = '0; seed_val = 1'b0; m_waitrequest = 1'b0; v_start = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_m_write", 64'(m_write), 64'(0));
      check("rst_m_address", 64'(m_address), 64'(0));
      check("rst_m_writedata", 64'(m_writedata), 64'(0));
      check("rst_busy_done", 64'({busy, done}), 64'(0));
      check("rst_gen_count", 64'(gen_count), 64'(0));
      check("byteenable", 64'(m_byteenable), 64'(4'hF));
      RESET = 1'b1;

      // Horizontal blinker becomes vertical at column 10
      clear_model();
      mdl[10][9] = 1'b1; mdl[10][10] = 1'b1; mdl[10][11] = 1'b1;
      load_grid(); life_step(); push_expected();
      run_pass(1'b1, 1585, 1'b0, 1'b0);
      check("blinker_r10_w5", 64'(vram[10*32+5]), 64'(32'h2000_2A10));
      check("blinker_r9_w5", 64'(vram[9*32+5]), 64'(32'h2000_2A10));
      check("blinker_r11_w5", 64'(vram[11*32+5]), 64'(32'h2000_2A10));
      check("blinker_r10_w4", 64'(vram[10*32+4]), 64'(32'h2000_2000));
      check("gen_after_blinker", 64'(gen_count), 64'(1));

      // Wrap-around: corner cells form a block across both seams; stall word 3
      clear_model();
      mdl[0][0] = 1'b1; mdl[0][63] = 1'b1; mdl[47][0] = 1'b1;
      load_grid(); life_step(); push_expected();
      run_pass(1'b1, 1590, 1'b1, 1'b0);
      check("wrap_r0_w0", 64'(vram[0]), 64'(32'h2000_2A10));
      check("wrap_r0_w31", 64'(vram[31]), 64'(32'h2A10_2000));
      check("wrap_r47_w0", 64'(vram[47*32]), 64'(32'h2000_2A10));
      check("wrap_r47_w31", 64'(vram[47*32+31]), 64'(32'h2A10_2000));
      check("gen_after_wrap", 64'(gen_count), 64'(2));

      // Republish with start and seed_we pulsed mid-pass; both must be ignored
      push_expected();
      run_pass(1'b0, 1585, 1'b0, 1'b1);
      check("guard_r5_w2", 64'(vram[5*32+2]), 64'(32'h2000_2000));
      check("guard_gen", 64'(gen_count), 64'(2));

      // Reset during row 7 writes
      life_step(); push_expected();
      @(negedge CLK);
      start = 1'b1; step = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      n = 0;
      while (!(m_write && m_address == 14'(7*32+3)) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      check("reset_point_reached", 64'(n < 3000), 64'(1));
      RESET = 1'b0;
      #2;
      check("midrst_m_write", 64'(m_write), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_gen", 64'(gen_count), 64'(0));
      exp_q.delete();
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      clear_model();
      mdl[10][9] = 1'b1; mdl[10][10] = 1'b1; mdl[10][11] = 1'b1;
      load_grid(); life_step(); push_expected();
      run_pass(1'b1, 1585, 1'b0, 1'b0);
      check("post_rst_gen", 64'(gen_count), 64'(1));
      check("post_rst_r10_w5", 64'(vram[10*32+5]), 64'(32'h2000_2A10));

      // Vsync-gated engine: vs already high must not release it
      @(negedge CLK);
      v_start = 1'b1; step = 1'b1;
      @(negedge CLK);
      v_start = 1'b0;
      repeat (20) @(negedge CLK);
      check("vs_wait_high", 64'({v_busy, v_write}), 64'(2'b10));
      vs = 1'b0;
      repeat (10) @(negedge CLK);
      check("vs_wait_low", 64'({v_busy, v_write}), 64'(2'b10));
      vs = 1'b1;
      n = 0;
      while (!v_write && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("vs_edge_to_write", 64'(n), 64'(4));
      check("vs_first_addr", 64'(v_address), 64'(0));
      n = 0;
      while (!v_done && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      check("vs_pass_done", 64'(v_done), 64'(1));
      check("vs_gen", 64'(v_gen), 64'(0));
      @(negedge CLK);
      check("vs_gen_after", 64'(v_gen), 64'(1));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
